// File: rtl/mem_stage_bridge_if.sv
// Memory-stage bridge bus bundle.
// Groups the M-stage pipeline inputs, the results sent back to the pipeline and CP0,
// the data-memory port and the peripheral req/ack port into one interface.
//   slave  : the bridge itself. It consumes the pipeline, DM-read and peripheral-response
//            signals and drives stall/exc_out/rdata plus the DM and peripheral requests.
//   master : the surrounding pipeline, DM and peripheral side.
// Parameter N_DEV sets the width of the one-hot peripheral select.
interface mem_stage_bridge_if #(
    parameter int N_DEV = 2
);
    // pipeline side
    logic             load;
    logic             store;
    logic [1:0]       be_op;
    logic             ov;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [4:0]       exc_in;
    logic             int_req;
    logic             stall;
    logic [4:0]       exc_out;
    logic [31:0]      rdata;
    // data memory
    logic             dm_we;
    logic [3:0]       dm_be;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wd;
    logic [31:0]      dm_rd;
    // peripheral bus
    logic             pr_req;
    logic             pr_we;
    logic [N_DEV-1:0] pr_sel;
    logic [31:0]      pr_addr;
    logic [3:0]       pr_be;
    logic [31:0]      pr_wd;
    logic             pr_ack;
    logic [31:0]      pr_rd;

    modport slave (
        input  load, store, be_op, ov, addr, wdata, exc_in, int_req, dm_rd, pr_ack, pr_rd,
        output stall, exc_out, rdata, dm_we, dm_be, dm_addr, dm_wd,
               pr_req, pr_we, pr_sel, pr_addr, pr_be, pr_wd
    );

    modport master (
        output load, store, be_op, ov, addr, wdata, exc_in, int_req, dm_rd, pr_ack, pr_rd,
        input  stall, exc_out, rdata, dm_we, dm_be, dm_addr, dm_wd,
               pr_req, pr_we, pr_sel, pr_addr, pr_be, pr_wd
    );
endinterface

// File: rtl/mem_stage_bridge.sv
// mem_stage_bridge: M-stage memory access unit.
// Decodes the M-stage address into the DM window or one of N_DEV peripheral windows.
// It resolves the address exceptions (AdEL=4, AdES=5) and issues the access.
// DM accesses complete in the same cycle. A peripheral access is a req/ack transaction.
// The transaction stalls the pipeline until the response has been captured.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mem_stage_bridge_if.slave: pipeline in/out, DM port, peripheral port
// Configuration macro BUS_TIMEOUT_EN adds a watchdog on peripheral accesses.
//   When it is defined, an access that gets no ack within TIMEOUT wait cycles
//   completes with bus-error code 7 and zero read data.
//   When it is undefined, the bridge waits for the ack indefinitely.
module mem_stage_bridge #(
    parameter logic [31:0]         DM_TOP   = 32'h0000_2fff,
    parameter int                  N_DEV    = 2,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {32'h7f10, 32'h7f00},
    parameter int                  DEV_SPAN = 12,
    parameter int                  RO_OFF   = 8,
    parameter int                  TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_bridge_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state, next;
    logic             isDm, anyDev, isHalf, isByte, isWord, addrFault, legal, start;
    logic [N_DEV-1:0] devHit, roHit;
    logic [3:0]       be;
    logic [4:0]       excComb;
    logic [N_DEV-1:0] selQ;
    logic             weQ;
    logic [31:0]      addrQ, wdQ, rdQ;
    logic [3:0]       beQ;
    logic             toHit, toQ;

    // Window decode. The compare is done at 33 bits so a window ending at the top of the
    // address space cannot wrap.
    assign isDm = bus.addr <= DM_TOP;
    for (genvar i = 0; i < N_DEV; i++) begin : g_dev
        assign devHit[i] = ({1'b0, bus.addr} >= {1'b0, DEV_BASE[32*i+:32]}) &&
                           ({1'b0, bus.addr} <  {1'b0, DEV_BASE[32*i+:32]} + 33'(DEV_SPAN));
        assign roHit[i]  = bus.addr == DEV_BASE[32*i+:32] + 32'(RO_OFF);
    end
    assign anyDev = |devHit;

    assign isHalf = bus.be_op == 2'b01;
    assign isByte = bus.be_op == 2'b10;
    assign isWord = !(isHalf || isByte);   // be_op 11 is treated as a word access

    always_comb begin
        be = 4'b1111;
        if (isHalf)      be = bus.addr[1] ? 4'b1100 : 4'b0011;
        else if (isByte) be = 4'b0001 << bus.addr[1:0];
    end

    // Every address fault maps to the same code, so the priority list reduces to an OR.
    assign addrFault = bus.ov || !(isDm || anyDev) ||
                       (isWord && bus.addr[1:0] != 2'b00) || (isHalf && bus.addr[0]) ||
                       ((isHalf || isByte) && anyDev) || (bus.store && |roHit);
    assign excComb = ((bus.load || bus.store) && addrFault) ? (bus.load ? 5'd4 : 5'd5)
                                                            : bus.exc_in;
    assign legal = (bus.load || bus.store) && excComb == bus.exc_in &&
                   bus.exc_in == 5'd0 && !bus.int_req;

    assign bus.dm_be   = be;
    assign bus.dm_addr = bus.addr;
    assign bus.dm_wd   = bus.wdata;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] toCnt;

    // toHit fires in the last allowed wait cycle, so the request is visible for the issue
    // cycle plus TIMEOUT wait cycles.
    assign toHit = state == S_WAIT && !bus.pr_ack && toCnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toCnt <= '0;
            toQ   <= 1'b0;
        end else begin
            if (start)               toCnt <= '0;
            else if (state == S_WAIT) toCnt <= toCnt + 1'b1;
            toQ <= toHit;   // only consulted in DONE, i.e. the cycle after leaving WAIT
        end
    end
`else
    assign toHit = 1'b0;
    assign toQ   = 1'b0;
`endif

    // The reset term keeps a held legal device access from raising pr_req while reset is
    // asserted.
    always_comb begin
        next        = state;
        start       = 1'b0;
        bus.stall   = 1'b0;
        bus.exc_out = excComb;
        bus.rdata   = bus.dm_rd;
        bus.dm_we   = 1'b0;
        bus.pr_req  = 1'b0;
        bus.pr_we   = 1'b0;
        bus.pr_sel  = '0;
        bus.pr_addr = bus.addr;
        bus.pr_be   = be;
        bus.pr_wd   = bus.wdata;
        case (state)
            S_IDLE: begin
                bus.dm_we = bus.store && legal && isDm;
                if (legal && anyDev && reset) begin
                    start      = 1'b1;
                    bus.pr_req = 1'b1;
                    bus.pr_sel = devHit;
                    bus.pr_we  = bus.store;
                    bus.stall  = 1'b1;
                    next       = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.pr_req  = 1'b1;
                bus.pr_sel  = selQ;
                bus.pr_we   = weQ;
                bus.pr_addr = addrQ;
                bus.pr_be   = beQ;
                bus.pr_wd   = wdQ;
                bus.stall   = 1'b1;
                if (bus.pr_ack || toHit) next = S_DONE;
            end
            S_DONE: begin
                bus.rdata   = rdQ;
                bus.exc_out = toQ ? 5'd7 : 5'd0;
                next        = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            selQ  <= '0;
            weQ   <= 1'b0;
            addrQ <= '0;
            beQ   <= '0;
            wdQ   <= '0;
            rdQ   <= '0;
        end else begin
            state <= next;
            if (start) begin
                selQ  <= devHit;
                weQ   <= bus.store;
                addrQ <= bus.addr;
                beQ   <= be;
                wdQ   <= bus.wdata;
            end
            if (state == S_WAIT && bus.pr_ack) rdQ <= bus.pr_rd;
            else if (toHit)                    rdQ <= '0;
        end
    end
endmodule

// File: tb/tb_mem_stage_bridge.sv
// Directed testbench for mem_stage_bridge with a small byte-enabled DM model.
// Cycle pattern: inputs are driven 1ns after the rising edge. Outputs are checked 1ns
// later, well before the next edge.
`timescale 1ns/1ps
module tb_mem_stage_bridge;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_stage_bridge_if #(.N_DEV(2)) bus ();
    mem_stage_bridge #(.N_DEV(2)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    logic [31:0] dmem [0:15];
    assign bus.dm_rd = dmem[bus.dm_addr[5:2]];
    always @(posedge clk)
        if (bus.dm_we)
            for (int b = 0; b < 4; b++)
                if (bus.dm_be[b]) dmem[bus.dm_addr[5:2]][8*b+:8] <= bus.dm_wd[8*b+:8];

    int nChk = 0;
    int nPass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setAcc(input logic ld, input logic st, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] wd);
        bus.load  = ld;
        bus.store = st;
        bus.be_op = op;
        bus.addr  = a;
        bus.wdata = wd;
    endtask

    // Called in the issue cycle. It counts stall cycles and raises pr_ack in wait cycle
    // ackCyc (0 = never).
    // In the first wait cycle it scrambles addr and raises int_req. The request fields must
    // be unaffected and the transaction must not abort.
    // It returns in the DONE cycle with the pipeline inputs idle and pr_rd changed.
    task automatic runXfer(input int ackCyc, input logic [31:0] expAddr,
                           input logic [1:0] expSel, output int nStall);
        nStall = 0;
        for (int c = 0; c < 64; c++) begin
            if (!bus.stall) break;
            nStall++;
            step();
            bus.pr_ack = (c + 1 == ackCyc);
            if (c == 0) begin
                bus.addr    = 32'hdead_beec;
                bus.int_req = 1'b1;
                #1;
                chk("waitReq", 32'(bus.pr_req), 32'd1);
                chk("waitAddr", bus.pr_addr, expAddr);
                chk("waitSel", 32'(bus.pr_sel), 32'(expSel));
            end else begin
                #1;
            end
        end
        bus.pr_ack  = 1'b0;
        bus.int_req = 1'b0;
        bus.load    = 1'b0;
        bus.store   = 1'b0;
        bus.pr_rd   = 32'h0bad_0bad;
        #1;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.store   = 1'b0;
        bus.be_op   = 2'b00;
        bus.ov      = 1'b0;
        bus.addr    = 32'h0;
        bus.wdata   = 32'h0;
        bus.exc_in  = 5'd3;
        bus.int_req = 1'b0;
        bus.pr_ack  = 1'b0;
        bus.pr_rd   = 32'h0;
        #12;
        chk("rstStall", 32'(bus.stall), 32'd0);
        chk("rstReq", 32'(bus.pr_req), 32'd0);
        chk("rstWe", 32'(bus.pr_we), 32'd0);
        chk("rstSel", 32'(bus.pr_sel), 32'd0);
        chk("rstExc", 32'(bus.exc_out), 32'd3);
        #1 rst_n = 1'b1;
        bus.exc_in = 5'd0;

        // DM word store then reload
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h10, 32'h1234_5678); #1;
        chk("swWe", 32'(bus.dm_we), 32'd1);
        chk("swBe", 32'(bus.dm_be), 32'hf);
        chk("swAddr", bus.dm_addr, 32'h10);
        chk("swStall", 32'(bus.stall), 32'd0);
        chk("swExc", 32'(bus.exc_out), 32'd0);
        chk("swReq", 32'(bus.pr_req), 32'd0);
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h10, 32'h0); #1;
        chk("lwRd", bus.rdata, 32'h1234_5678);
        chk("lwWe", 32'(bus.dm_we), 32'd0);
        chk("lwStall", 32'(bus.stall), 32'd0);

        // Byte and half lanes
        step(); setAcc(1'b0, 1'b1, 2'b10, 32'h13, 32'hab00_0000); #1;
        chk("sbBe", 32'(bus.dm_be), 32'h8);
        step(); setAcc(1'b0, 1'b1, 2'b01, 32'h10, 32'h0000_beef); #1;
        chk("shBe", 32'(bus.dm_be), 32'h3);
        step(); setAcc(1'b1, 1'b0, 2'b01, 32'h12, 32'h0); #1;
        chk("lhBeHi", 32'(bus.dm_be), 32'hc);
        chk("lhExc", 32'(bus.exc_out), 32'd0);
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h10, 32'h0); #1;
        chk("lwMerge", bus.rdata, 32'hab34_beef);

        // Address exceptions
        step(); setAcc(1'b1, 1'b0, 2'b01, 32'h11, 32'h0); #1;
        chk("lhMisExc", 32'(bus.exc_out), 32'd4);
        step(); setAcc(1'b0, 1'b1, 2'b01, 32'h11, 32'h0); #1;
        chk("shMisExc", 32'(bus.exc_out), 32'd5);
        chk("shMisWe", 32'(bus.dm_we), 32'd0);
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h12, 32'h0); #1;
        chk("lwMisExc", 32'(bus.exc_out), 32'd4);
        step(); setAcc(1'b0, 1'b1, 2'b10, 32'h7f00, 32'h0); #1;
        chk("sbDevExc", 32'(bus.exc_out), 32'd5);
        chk("sbDevReq", 32'(bus.pr_req), 32'd0);
        step(); setAcc(1'b1, 1'b0, 2'b10, 32'h7f04, 32'h0); #1;
        chk("lbDevExc", 32'(bus.exc_out), 32'd4);
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h7f08, 32'h0); #1;
        chk("swRoExc", 32'(bus.exc_out), 32'd5);
        chk("swRoReq", 32'(bus.pr_req), 32'd0);
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h7f0c, 32'h0); #1;
        chk("lwSpanExc", 32'(bus.exc_out), 32'd4);
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h2ffc, 32'h0); #1;
        chk("lwDmTopExc", 32'(bus.exc_out), 32'd0);
        chk("lwDmTopStall", 32'(bus.stall), 32'd0);
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h3000, 32'h0); #1;
        chk("lwHoleExc", 32'(bus.exc_out), 32'd4);
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h3000, 32'h0); bus.int_req = 1'b1; #1;
        chk("swHoleIntExc", 32'(bus.exc_out), 32'd5);
        chk("swHoleIntWe", 32'(bus.dm_we), 32'd0);
        chk("swHoleIntReq", 32'(bus.pr_req), 32'd0);
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h10, 32'h0); #1;
        chk("swIntWe", 32'(bus.dm_we), 32'd0);
        chk("swIntExc", 32'(bus.exc_out), 32'd0);
        bus.int_req = 1'b0;
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h10, 32'h0); bus.ov = 1'b1; #1;
        chk("ovExc", 32'(bus.exc_out), 32'd4);
        bus.ov = 1'b0;
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h10, 32'h0); bus.exc_in = 5'd3; #1;
        chk("excInPass", 32'(bus.exc_out), 32'd3);
        chk("excInWe", 32'(bus.dm_we), 32'd0);
        bus.exc_in = 5'd0;

        // Device 0 load. An ack in the issue cycle is ignored; the real ack arrives in wait cycle 3.
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h7f08, 32'h0);
        bus.pr_rd = 32'hcafe_f00d; bus.pr_ack = 1'b1; #1;
        chk("issReq", 32'(bus.pr_req), 32'd1);
        chk("issSel", 32'(bus.pr_sel), 32'h1);
        chk("issWe", 32'(bus.pr_we), 32'd0);
        chk("issBe", 32'(bus.pr_be), 32'hf);
        chk("issStall", 32'(bus.stall), 32'd1);
        runXfer(3, 32'h7f08, 2'b01, n);
        chk("lwDevStall", 32'(n), 32'd4);
        chk("lwDevRd", bus.rdata, 32'hcafe_f00d);
        chk("lwDevExc", 32'(bus.exc_out), 32'd0);
        chk("lwDevDoneReq", 32'(bus.pr_req), 32'd0);

        // Device 1 store, ack in first wait cycle
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h7f14, 32'h5555_aaaa); bus.pr_ack = 1'b0; #1;
        chk("swDevWe", 32'(bus.pr_we), 32'd1);
        chk("swDevSel", 32'(bus.pr_sel), 32'h2);
        chk("swDevWd", bus.pr_wd, 32'h5555_aaaa);
        runXfer(1, 32'h7f14, 2'b10, n);
        chk("swDevStall", 32'(n), 32'd2);
        chk("swDevExc", 32'(bus.exc_out), 32'd0);

        // Load with a late or missing ack
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h7f14, 32'h0);
        bus.pr_rd = 32'h1111_2222; #1;
`ifdef BUS_TIMEOUT_EN
        runXfer(0, 32'h7f14, 2'b10, n);
        chk("toStall", 32'(n), 32'd17);
        chk("toExc", 32'(bus.exc_out), 32'd7);
        chk("toRd", bus.rdata, 32'h0);
`else
        runXfer(30, 32'h7f14, 2'b10, n);
        chk("slowStall", 32'(n), 32'd31);
        chk("slowExc", 32'(bus.exc_out), 32'd0);
        chk("slowRd", bus.rdata, 32'h1111_2222);
`endif

        // Reset in the middle of a transaction
        step(); setAcc(1'b1, 1'b0, 2'b00, 32'h7f00, 32'h0); #1;
        chk("midIssReq", 32'(bus.pr_req), 32'd1);
        step(); #1;
        chk("midWaitReq", 32'(bus.pr_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("midRstReq", 32'(bus.pr_req), 32'd0);
        chk("midRstStall", 32'(bus.stall), 32'd0);
        setAcc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1 rst_n = 1'b1;
        step(); setAcc(1'b0, 1'b1, 2'b00, 32'h7f04, 32'h0f0f_0f0f); #1;
        chk("postReq", 32'(bus.pr_req), 32'd1);
        chk("postWe", 32'(bus.pr_we), 32'd1);
        chk("postWd", bus.pr_wd, 32'h0f0f_0f0f);
        runXfer(2, 32'h7f04, 2'b01, n);
        chk("postStall", 32'(n), 32'd3);
        chk("postExc", 32'(bus.exc_out), 32'd0);
        step(); #1;
        chk("finalStall", 32'(bus.stall), 32'd0);
        chk("finalReq", 32'(bus.pr_req), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
